vga_frame_streamer: RTL and testbench

- Parametrised successor of the fixed 640x480 VGA timing/fetch block.
- Generates configurable H/V timing and streams 1-bpp pixel words supplied by the CPU through a ready/valid port into a small prefetch FIFO.
- Supports frame repeat with blanked repeats, a picture sequence counter with restart, and underflow detection.
- Sits between the CPU/memory-mapped feeder and the VGA pins.

---
 rtl/vga_frame_streamer_pkg.sv | 38 +++
 rtl/vga_frame_streamer_stream_fifo.sv | 61 ++++++
 rtl/vga_frame_streamer.sv | 207 ++++++++++++++++++++
 tb/tb_vga_frame_streamer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/vga_frame_streamer_pkg.sv
// Shared timing defaults for the VGA frame streamer and a helper that derives
// line/frame totals and the number of words fetched per displayed frame.
package vga_stream_pkg;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_HS_POL     = 0;
  localparam int DEF_VS_POL     = 0;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_REPEAT_NUM = 2;
  localparam int DEF_PICT_NUM   = 6;

  typedef struct packed {
    logic [31:0] h_total;
    logic [31:0] v_total;
    logic [31:0] wpf;
  } frame_dims_t;

  function automatic frame_dims_t calc_dims(input int h_active, input int h_fp,
                                            input int h_sync, input int h_bp,
                                            input int v_active, input int v_fp,
                                            input int v_sync, input int v_bp,
                                            input int word_w);
    frame_dims_t d;
    d.h_total = 32'(h_active + h_fp + h_sync + h_bp);
    d.v_total = 32'(v_active + v_fp + v_sync + v_bp);
    d.wpf     = 32'((h_active / word_w) * v_active);
    return d;
  endfunction

endpackage

// File: rtl/vga_frame_streamer_stream_fifo.sv
// Small synchronous first-word-fall-through FIFO; rdata shows the head entry.
// Pops on empty and pushes on full without a same-cycle pop are ignored.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests against the current fill level.
  always_comb begin
    do_pop_s  = pop && (count_r != {(AW + 1){1'b0}});
    do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);
  end

  // Pointer and level state; reset flushes the contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == {(AW + 1){1'b0}});
  assign count = count_r;

endmodule

// File: rtl/vga_frame_streamer.sv
// Configurable VGA timing generator streaming 1-bpp words from a CPU feeder
// through a prefetch FIFO, with blanked repeat scans and a picture sequencer.
module vga_frame_streamer
  import vga_stream_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int HS_POL     = DEF_HS_POL,
  parameter int VS_POL     = DEF_VS_POL,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int REPEAT_NUM = DEF_REPEAT_NUM,
  parameter int PICT_NUM   = DEF_PICT_NUM
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [WORD_W-1:0]           in_data,
  output logic                        in_ready,
  output logic                        hs,
  output logic                        vs,
  output logic                        de,
  output logic                        pixel,
  output logic [WORD_W-1:0]           o_data,
  output logic                        intr,
  output logic                        restart,
  output logic [$clog2(PICT_NUM)-1:0] pict_idx,
  output logic                        underflow
);

  localparam frame_dims_t DIMS = calc_dims(H_ACTIVE, H_FP, H_SYNC, H_BP,
                                           V_ACTIVE, V_FP, V_SYNC, V_BP, WORD_W);
  localparam int H_TOTAL = int'(DIMS.h_total);
  localparam int V_TOTAL = int'(DIMS.v_total);
  localparam int WPF     = int'(DIMS.wpf);
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int FW      = $clog2(WPF + 1);
  localparam int RW      = (REPEAT_NUM > 1) ? $clog2(REPEAT_NUM) : 1;
  localparam int PW      = $clog2(PICT_NUM);
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_WORD    = HW'(WORD_W);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [FW-1:0] WPF_C     = FW'(WPF);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_NUM - 1);
  localparam logic [PW-1:0] PICT_LAST = PW'(PICT_NUM - 1);
  localparam logic          HS_ON     = 1'(HS_POL);
  localparam logic          VS_ON     = 1'(VS_POL);

  logic [HW-1:0]     h_cnt_r;
  logic [VW-1:0]     v_cnt_r;
  logic [RW-1:0]     rep_cnt_r;
  logic [PW-1:0]     pict_idx_r;
  logic [FW-1:0]     wf_r;
  logic              boot_r, intr_r, restart_r, underflow_r;
  logic              hs_r, vs_r, de_r, pixel_r;
  logic [WORD_W-1:0] o_data_r, shift_r;

  logic              h_last_s, v_last_s, active_s, disp_s, word_start_s;
  logic              slot_s, pop_s, starve_s, fetch_open_s, frame_top_s, push_s;
  logic [WORD_W-1:0] next_word_s, fifo_rdata_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [CW-1:0]     unused_fifo_count_s;

  stream_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (in_data),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (unused_fifo_count_s)
  );

  // Decode counter position into display, pop and fetch-window events.
  always_comb begin
    h_last_s     = (h_cnt_r == H_LAST);
    v_last_s     = (v_cnt_r == V_LAST);
    active_s     = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    disp_s       = (rep_cnt_r == {RW{1'b0}});
    word_start_s = ((h_cnt_r % H_WORD) == {HW{1'b0}});
    slot_s       = active_s && disp_s && word_start_s;
    pop_s        = slot_s && !fifo_empty_s;
    starve_s     = slot_s && fifo_empty_s;
    frame_top_s  = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}}) && disp_s;
    fetch_open_s = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == V_ACT) && (rep_cnt_r == REP_LAST);
    if (pop_s) next_word_s = fifo_rdata_s;
    else       next_word_s = {WORD_W{1'b0}};
  end

  assign in_ready = !fifo_full_s && (wf_r < WPF_C);
  assign push_s   = in_valid && in_ready;

  // Pixel/line counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_r <= {HW{1'b0}};
      v_cnt_r <= {VW{1'b0}};
    end else if (h_last_s) begin
      h_cnt_r <= {HW{1'b0}};
      v_cnt_r <= v_last_s ? {VW{1'b0}} : v_cnt_r + VW'(1);
    end else begin
      h_cnt_r <= h_cnt_r + HW'(1);
    end
  end

  // Repeat scan and picture sequencing at the last pixel of each frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_r  <= {RW{1'b0}};
      pict_idx_r <= {PW{1'b0}};
      restart_r  <= 1'b0;
    end else if (h_last_s && v_last_s) begin
      if (rep_cnt_r == REP_LAST) begin
        rep_cnt_r <= {RW{1'b0}};
        if (pict_idx_r == PICT_LAST) begin
          pict_idx_r <= {PW{1'b0}};
          restart_r  <= 1'b1;
        end else begin
          pict_idx_r <= pict_idx_r + PW'(1);
          restart_r  <= 1'b0;
        end
      end else begin
        rep_cnt_r <= rep_cnt_r + RW'(1);
        restart_r <= 1'b0;
      end
    end else begin
      restart_r <= 1'b0;
    end
  end

  // Fetch window: a late word accepted as the window reopens counts toward the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      boot_r <= 1'b1;
      intr_r <= 1'b0;
      wf_r   <= {FW{1'b0}};
    end else begin
      boot_r <= 1'b0;
      intr_r <= boot_r || fetch_open_s;
      if (fetch_open_s)  wf_r <= push_s ? FW'(1) : {FW{1'b0}};
      else if (push_s)   wf_r <= wf_r + FW'(1);
      else               wf_r <= wf_r;
    end
  end

  // Registered video outputs, one cycle behind the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_r        <= ~HS_ON;
      vs_r        <= ~VS_ON;
      de_r        <= 1'b0;
      pixel_r     <= 1'b0;
      o_data_r    <= {WORD_W{1'b0}};
      shift_r     <= {WORD_W{1'b0}};
      underflow_r <= 1'b0;
    end else begin
      hs_r <= ((h_cnt_r >= HS_BEGIN) && (h_cnt_r < HS_END)) ? HS_ON : ~HS_ON;
      vs_r <= ((v_cnt_r >= VS_BEGIN) && (v_cnt_r < VS_END)) ? VS_ON : ~VS_ON;
      de_r <= active_s;
      if (active_s && disp_s) begin
        if (word_start_s) begin
          pixel_r  <= next_word_s[WORD_W-1];
          shift_r  <= next_word_s << 1;
          o_data_r <= next_word_s;
        end else begin
          pixel_r  <= shift_r[WORD_W-1];
          shift_r  <= shift_r << 1;
        end
      end else begin
        pixel_r  <= 1'b0;
        shift_r  <= {WORD_W{1'b0}};
        o_data_r <= {WORD_W{1'b0}};
      end
      if (starve_s)         underflow_r <= 1'b1;
      else if (frame_top_s) underflow_r <= 1'b0;
      else                  underflow_r <= underflow_r;
    end
  end

  assign hs        = hs_r;
  assign vs        = vs_r;
  assign de        = de_r;
  assign pixel     = pixel_r;
  assign o_data    = o_data_r;
  assign intr      = intr_r;
  assign restart   = restart_r;
  assign pict_idx  = pict_idx_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_vga_frame_streamer.sv
// Self-checking bench for vga_frame_streamer on a reduced 64x4 timing with a
// time-indexed reference model and a queue standing in for the prefetch FIFO.
module tb_vga_frame_streamer;

  localparam int H_ACT = 64, H_FP = 2, H_SY = 4, H_BP = 2;
  localparam int V_ACT = 4, V_FP = 1, V_SY = 1, V_BP = 1;
  localparam int WW = 32, DEPTH = 4, REP = 2, PICT = 3;
  localparam int HT  = H_ACT + H_FP + H_SY + H_BP;
  localparam int VT  = V_ACT + V_FP + V_SY + V_BP;
  localparam int FT  = HT * VT;
  localparam int WPF = (H_ACT / WW) * V_ACT;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, hs, vs, de, pixel, intr, restart, underflow;
  logic [31:0] in_data, o_data;
  logic [1:0]  pict_idx;

  int          checks = 0;
  int          errors = 0;
  int          n;
  logic [31:0] q[$];
  logic [31:0] cur_word;
  logic [31:0] pend_word;
  int          word_idx;
  bit          uf;
  int          wf;

  vga_frame_streamer #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .HS_POL(0), .VS_POL(0), .WORD_W(WW), .FIFO_DEPTH(DEPTH),
    .REPEAT_NUM(REP), .PICT_NUM(PICT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .hs(hs), .vs(vs), .de(de), .pixel(pixel),
    .o_data(o_data), .intr(intr), .restart(restart), .pict_idx(pict_idx),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic int hh(input int t); return t % HT; endfunction
  function automatic int vv(input int t); return (t / HT) % VT; endfunction
  function automatic int rep_of(input int t); return (t / FT) % REP; endfunction
  function automatic int pic_of(input int t); return (t / FT / REP) % PICT; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hs"}, {31'd0, hs}, 32'd1);
    chk({tag, "_vs"}, {31'd0, vs}, 32'd1);
    chk({tag, "_de"}, {31'd0, de}, 32'd0);
    chk({tag, "_pixel"}, {31'd0, pixel}, 32'd0);
    chk({tag, "_odata"}, o_data, 32'd0);
    chk({tag, "_intr"}, {31'd0, intr}, 32'd0);
    chk({tag, "_restart"}, {31'd0, restart}, 32'd0);
    chk({tag, "_pict"}, {30'd0, pict_idx}, 32'd0);
    chk({tag, "_underflow"}, {31'd0, underflow}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic model_reset();
    n = 0;
    q.delete();
    cur_word = 32'd0;
    uf = 1'b0;
    wf = 0;
  endtask

  // One clock: drive inputs, advance the model for counter time t, compare outputs.
  task automatic step(input logic v, input logic [31:0] d, output bit acc);
    int t;
    bit act, disp, slot, rdy, open_w, sync_h, sync_v;
    logic [31:0] exp_pix, exp_od;
    t = n;
    rdy = (q.size() < DEPTH) && (wf < WPF);
    in_valid = v;
    in_data = d;
    @(posedge clk);
    #1;
    act  = (hh(t) < H_ACT) && (vv(t) < V_ACT);
    disp = (rep_of(t) == 0);
    slot = act && disp && (hh(t) % WW == 0);
    if (slot && q.size() == 0) begin
      uf = 1'b1;
      cur_word = 32'd0;
    end else if (slot) begin
      cur_word = q.pop_front();
      if (hh(t) == 0 && vv(t) == 0) uf = 1'b0;
    end
    acc = v && rdy;
    open_w = (hh(t) == 0) && (vv(t) == V_ACT) && (rep_of(t) == REP - 1);
    if (acc) q.push_back(d);
    if (open_w) wf = acc ? 1 : 0;
    else if (acc) wf++;
    n++;
    sync_h = (hh(t) >= H_ACT + H_FP) && (hh(t) < H_ACT + H_FP + H_SY);
    sync_v = (vv(t) >= V_ACT + V_FP) && (vv(t) < V_ACT + V_FP + V_SY);
    exp_pix = (act && disp) ? {31'd0, cur_word[31 - (hh(t) % WW)]} : 32'd0;
    exp_od  = (act && disp) ? cur_word : 32'd0;
    chk("hs", {31'd0, hs}, sync_h ? 32'd0 : 32'd1);
    chk("vs", {31'd0, vs}, sync_v ? 32'd0 : 32'd1);
    chk("de", {31'd0, de}, act ? 32'd1 : 32'd0);
    chk("pixel", {31'd0, pixel}, exp_pix);
    chk("o_data", o_data, exp_od);
    chk("intr", {31'd0, intr}, ((n == 1) || open_w) ? 32'd1 : 32'd0);
    chk("restart", {31'd0, restart},
        ((n % FT == 0) && ((n / FT) % (REP * PICT) == 0)) ? 32'd1 : 32'd0);
    chk("pict_idx", {30'd0, pict_idx}, 32'(pic_of(n)));
    chk("underflow", {31'd0, underflow}, uf ? 32'd1 : 32'd0);
    chk("in_ready", {31'd0, in_ready},
        ((q.size() < DEPTH) && (wf < WPF)) ? 32'd1 : 32'd0);
  endtask

  task automatic feed(input logic v, output bit acc);
    step(v, pend_word, acc);
    if (acc) begin
      word_idx++;
      pend_word = (word_idx == 1) ? 32'hFFFF_0000 : $urandom;
    end
  endtask

  initial begin
    bit acc;
    int acc_b;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 32'd0;
    pend_word = 32'h8000_0001;
    word_idx = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b1;

    // Picture 0 and its blanked repeat up to the fetch window, feed always valid.
    while (n < FT + V_ACT * HT) feed(1'b1, acc);

    // Starve picture 1 after three words.
    acc_b = 0;
    while (n < 3 * FT + V_ACT * HT) begin
      feed(acc_b < 3, acc);
      if (acc) acc_b++;
    end

    // Feed restored with random gaps through the sequence restart.
    while (n < 8 * FT) feed($urandom_range(0, 3) != 0, acc);

    // Reset mid-line with words queued.
    for (int k = 0; k < 2000; k++) begin
      if (q.size() == 2 && hh(n) > 8 && hh(n) < 60 && vv(n) < V_ACT) break;
      feed($urandom_range(0, 3) != 0, acc);
    end
    rst = 1'b0;
    in_valid = 1'b1;
    #1;
    check_reset("midrst");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset("inrst");
    end
    model_reset();
    rst = 1'b1;
    while (n < 2 * FT) feed($urandom_range(0, 3) != 0, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
